// File: rtl/dp_ram_be_clr.sv
// -----------------------------------------------------------------------------
// dp_ram_be_clr
//   Simple dual-port synchronous RAM (one write port, one read port, one clock)
//   with per-lane byte enables, a read enable with a valid flag, a selectable
//   read latency of 1 or 2 cycles, a defined same-address read-during-write
//   result, and a clear engine. The clear engine writes init_val to every word
//   after reset and whenever a clear is requested.
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   clear      single-cycle request to restart the clear sweep (honoured in IDLE)
//   busy       high while the clear sweep runs; user accesses are ignored then
//   wraddress  write address
//   wren       write enable
//   byteen     lane mask; lane i covers data[i*lane_w +: lane_w]
//   data       write data
//   rdaddress  read address
//   rden       read enable
//   q          read data; holds its last value when no read completes
//   q_valid    high in the cycle q carries a completed read
// -----------------------------------------------------------------------------
module dp_ram_be_clr #(
    parameter int               width      = 32,
    parameter int               widthad    = 6,
    parameter int               lane_w     = 8,
    parameter int               rd_latency = 1,
    parameter int               rdw_new    = 0,
    parameter logic [width-1:0] init_val   = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    output logic                      busy,
    input  logic [widthad-1:0]        wraddress,
    input  logic                      wren,
    input  logic [width/lane_w-1:0]   byteen,
    input  logic [width-1:0]          data,
    input  logic [widthad-1:0]        rdaddress,
    input  logic                      rden,
    output logic [width-1:0]          q,
    output logic                      q_valid
);

    localparam int depth  = 2 ** widthad;
    localparam int nlanes = width / lane_w;
    localparam logic [widthad-1:0] last_addr = '1;

    generate
        if ((width % lane_w) != 0) begin : g_bad_width
            $error("dp_ram_be_clr: width must be a multiple of lane_w");
        end
        if ((rd_latency != 1) && (rd_latency != 2)) begin : g_bad_latency
            $error("dp_ram_be_clr: rd_latency must be 1 or 2");
        end
    endgenerate

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [widthad-1:0]  ptr_q, ptr_d;

    // Shared write-port controls: the sweep owns the port while in CLEAR.
    logic [nlanes-1:0]   wr_lane_en;
    logic [widthad-1:0]  wr_addr;
    logic [width-1:0]    wr_word;
    logic                rd_fire;
    logic [width-1:0]    rd_word;

    // Read stage 1 (registered read)
    logic                rd_v1_q, rd_v1_d;
    logic [width-1:0]    rd_d1_q, rd_d1_d;

    // ---------------------------------------------------------------- FSM
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            S_CLEAR: begin
                // Pointer saturates on the last word; no second pass.
                if (ptr_q == last_addr) begin
                    state_d = S_IDLE;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (clear) begin
                    state_d = S_CLEAR;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = S_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    always_comb begin
        wr_lane_en = '0;
        wr_addr    = wraddress;
        wr_word    = data;
        rd_fire    = 1'b0;
        if (state_q == S_CLEAR) begin
            wr_lane_en = '1;
            wr_addr    = ptr_q;
            wr_word    = init_val;
        end else begin
            // A clear request in this cycle still lets this access through.
            wr_lane_en = wren ? byteen : '0;
            rd_fire    = rden;
        end
    end

    // --------------------------------------------------------- lane memories
    // One array per lane so each lane write is an independent enable.
    generate
        for (genvar gi = 0; gi < nlanes; gi++) begin : g_lane
            logic [lane_w-1:0] mem [depth];
            logic              rdw_hit;

            always_ff @(posedge clk) begin
                if (wr_lane_en[gi]) begin
                    mem[wr_addr] <= wr_word[gi*lane_w +: lane_w];
                end
            end

            // New-data mode forwards the incoming lane on a same-address
            // collision; unenabled lanes naturally fall back to the old word.
            assign rdw_hit = (rdw_new != 0) && wr_lane_en[gi] && (wr_addr == rdaddress);
            assign rd_word[gi*lane_w +: lane_w] =
                rdw_hit ? wr_word[gi*lane_w +: lane_w] : mem[rdaddress];
        end
    endgenerate

    // ------------------------------------------------------------ read path
    always_comb begin
        rd_v1_d = rd_fire;
        rd_d1_d = rd_fire ? rd_word : rd_d1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_CLEAR;
            ptr_q   <= '0;
            rd_v1_q <= 1'b0;
            rd_d1_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rd_v1_q <= rd_v1_d;
            rd_d1_q <= rd_d1_d;
        end
    end

    assign busy = (state_q == S_CLEAR);

    generate
        if (rd_latency == 2) begin : g_lat2
            logic             rd_v2_q, rd_v2_d;
            logic [width-1:0] rd_d2_q, rd_d2_d;

            always_comb begin
                rd_v2_d = rd_v1_q;
                rd_d2_d = rd_v1_q ? rd_d1_q : rd_d2_q;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_v2_q <= 1'b0;
                    rd_d2_q <= '0;
                end else begin
                    rd_v2_q <= rd_v2_d;
                    rd_d2_q <= rd_d2_d;
                end
            end

            assign q       = rd_d2_q;
            assign q_valid = rd_v2_q;
        end else begin : g_lat1
            assign q       = rd_d1_q;
            assign q_valid = rd_v1_q;
        end
    endgenerate

endmodule

// File: tb/tb_dp_ram_be_clr.sv
// -----------------------------------------------------------------------------
// tb_dp_ram_be_clr
//   Two instances share one stimulus stream:
//     A: widthad=4, rd_latency=1, old-data RDW, init_val=A5A5A5A5
//     B: widthad=4, rd_latency=2, new-data RDW, init_val=00000000
//   Each issued read pushes its hand-computed word and the cycle it must
//   appear into a per-instance queue; a monitor per instance pops on q_valid.
// -----------------------------------------------------------------------------
module tb_dp_ram_be_clr;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clear = 1'b0;
    logic        wren = 1'b0;
    logic        rden = 1'b0;
    logic [3:0]  wraddress = '0;
    logic [3:0]  rdaddress = '0;
    logic [3:0]  byteen = '0;
    logic [31:0] data = '0;

    logic        busy_a, busy_b, qv_a, qv_b;
    logic [31:0] q_a, q_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] d;
        int          c;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];
    exp_t ea, eb;

    dp_ram_be_clr #(
        .width(32), .widthad(4), .lane_w(8), .rd_latency(1), .rdw_new(0),
        .init_val(32'hA5A5A5A5)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .busy(busy_a),
        .wraddress(wraddress), .wren(wren), .byteen(byteen), .data(data),
        .rdaddress(rdaddress), .rden(rden), .q(q_a), .q_valid(qv_a)
    );

    dp_ram_be_clr #(
        .width(32), .widthad(4), .lane_w(8), .rd_latency(2), .rdw_new(1),
        .init_val(32'h00000000)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .busy(busy_b),
        .wraddress(wraddress), .wren(wren), .byteen(byteen), .data(data),
        .rdaddress(rdaddress), .rden(rden), .q(q_b), .q_valid(qv_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("check %s: %h ok", name, act);
        end
    endtask

    // ------------------------------------------------------------ monitors
    always @(negedge clk) begin
        if (qv_a === 1'b1) begin
            checks++;
            if (sb_a.size() == 0) begin
                errors++;
                $display("FAIL a_unexpected_valid: got q=%h at cycle %0d, expected no read", q_a, cyc);
            end else begin
                ea = sb_a.pop_front();
                if (q_a !== ea.d || cyc != ea.c) begin
                    errors++;
                    $display("FAIL a_read: got %h at cycle %0d, expected %h at cycle %0d", q_a, cyc, ea.d, ea.c);
                end else begin
                    $display("read A: %h at cycle %0d ok", q_a, cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (qv_b === 1'b1) begin
            checks++;
            if (sb_b.size() == 0) begin
                errors++;
                $display("FAIL b_unexpected_valid: got q=%h at cycle %0d, expected no read", q_b, cyc);
            end else begin
                eb = sb_b.pop_front();
                if (q_b !== eb.d || cyc != eb.c) begin
                    errors++;
                    $display("FAIL b_read: got %h at cycle %0d, expected %h at cycle %0d", q_b, cyc, eb.d, eb.c);
                end else begin
                    $display("read B: %h at cycle %0d ok", q_b, cyc);
                end
            end
        end
    end

    // ------------------------------------------------------------ stimulus
    task automatic tick();
        @(negedge clk);
        wren  = 1'b0;
        rden  = 1'b0;
        clear = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        wren      = 1'b1;
        wraddress = a;
        data      = d;
        byteen    = be;
    endtask

    // Expected cycles: A (latency 1) one cycle after issue, B two.
    task automatic rd(input logic [3:0] a, input logic [31:0] exp_a, input logic [31:0] exp_b);
        exp_t e;
        rden      = 1'b1;
        rdaddress = a;
        e.d = exp_a; e.c = cyc + 1; sb_a.push_back(e);
        e.d = exp_b; e.c = cyc + 2; sb_b.push_back(e);
    endtask

    // Counts negedges with busy high, starting at the current one.
    task automatic count_busy(input bit poke, output int na, output int nb);
        na = 0;
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy_a && !busy_b) break;
            na += int'(busy_a);
            nb += int'(busy_b);
            if (poke) begin
                wren = 1'b1; wraddress = 4'd9; data = 32'h99999999; byteen = 4'hF;
                rden = 1'b1; rdaddress = 4'd9;
            end
            @(negedge clk);
        end
        wren = 1'b0;
        rden = 1'b0;
    endtask

    int na, nb;

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("a_reset_busy", busy_a, 1);
        chk("b_reset_busy", busy_b, 1);
        chk("a_reset_qv", qv_a, 0);
        chk("b_reset_qv", qv_b, 0);
        chk("a_reset_q", q_a, 0);
        chk("b_reset_q", q_b, 0);

        // Release and sweep
        rst_n = 1'b1;
        count_busy(1'b0, na, nb);
        chk("a_sweep_len", na, 16);
        chk("b_sweep_len", nb, 16);

        // Every word holds init_val; back-to-back reads
        for (int i = 0; i < 16; i++) begin
            rd(4'(i), 32'hA5A5A5A5, 32'h00000000);
            tick();
        end
        repeat (3) tick();

        // Byte-enable merge
        wr(4'd3, 32'h11223344, 4'b0101); tick();
        rd(4'd3, 32'hA522A544, 32'h00220044); tick();

        // Same-address read-during-write
        wr(4'd7, 32'hDEADBEEF, 4'hF); tick();
        wr(4'd7, 32'h01020304, 4'hF); rd(4'd7, 32'hDEADBEEF, 32'h01020304); tick();
        rd(4'd7, 32'h01020304, 32'h01020304); tick();
        wr(4'd7, 32'hAABBCCDD, 4'b0011); rd(4'd7, 32'h01020304, 32'h0102CCDD); tick();
        rd(4'd7, 32'h0102CCDD, 32'h0102CCDD); tick();
        wr(4'd2, 32'h12345678, 4'h0); tick();   // no-op write
        rd(4'd2, 32'hA5A5A5A5, 32'h00000000); tick();

        // Consecutive reads, plus a different-address write alongside
        for (int i = 0; i < 4; i++) begin
            wr(4'(i), 32'h10000000 + i, 4'hF); tick();
        end
        for (int i = 0; i < 4; i++) begin
            if (i == 3) wr(4'd4, 32'hCAFEF00D, 4'hF);
            rd(4'(i), 32'h10000000 + i, 32'h10000000 + i);
            tick();
        end
        rd(4'd4, 32'hCAFEF00D, 32'hCAFEF00D); tick();
        repeat (3) tick();
        chk("a_q_hold", q_a, 32'hCAFEF00D);
        chk("b_q_hold", q_b, 32'hCAFEF00D);

        // Clear request with a same-cycle write and read
        clear = 1'b1;
        wr(4'd5, 32'h55555555, 4'hF);
        rd(4'd3, 32'h10000003, 32'h10000003);
        tick();
        count_busy(1'b1, na, nb);
        chk("a_clear_len", na, 16);
        chk("b_clear_len", nb, 16);
        for (int i = 0; i < 16; i++) begin
            rd(4'(i), 32'hA5A5A5A5, 32'h00000000);
            tick();
        end
        repeat (3) tick();

        // Reset in the middle of a sweep
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #2;
        chk("a_midreset_busy", busy_a, 1);
        chk("a_midreset_qv", qv_a, 0);
        chk("a_midreset_q", q_a, 0);
        chk("b_midreset_q", q_b, 0);
        @(negedge clk);
        rst_n = 1'b1;
        count_busy(1'b0, na, nb);
        chk("a_resweep_len", na, 16);
        chk("b_resweep_len", nb, 16);
        rd(4'd15, 32'hA5A5A5A5, 32'h00000000); tick();
        rd(4'd0, 32'hA5A5A5A5, 32'h00000000); tick();
        repeat (4) tick();

        chk("a_sb_empty", sb_a.size(), 0);
        chk("b_sb_empty", sb_b.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
